// File: rtl/fetch_queue_if.sv
// Fetch-queue bus bundle: IMEM request/response channel plus the decode-side channel.
// master = fetch_queue, slave = memory/decode environment.
interface fetch_queue_if;
    logic        IMEM_Req_Valid;
    logic        IMEM_Req_Ready;
    logic [31:0] IMEM_Addr;
    logic        IMEM_Resp_Valid;
    logic [31:0] IMEM_Resp_Data;
    logic        Stall_D;
    logic        Flush;
    logic [31:0] Redirect_PC;
    logic        Valid_D;
    logic [31:0] Instr_D;
    logic [31:0] PC_D;

    modport master (
        output IMEM_Req_Valid, IMEM_Addr, Valid_D, Instr_D, PC_D,
        input  IMEM_Req_Ready, IMEM_Resp_Valid, IMEM_Resp_Data, Stall_D, Flush, Redirect_PC
    );

    modport slave (
        input  IMEM_Req_Valid, IMEM_Addr, Valid_D, Instr_D, PC_D,
        output IMEM_Req_Ready, IMEM_Resp_Valid, IMEM_Resp_Data, Stall_D, Flush, Redirect_PC
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch front end: PC, credit-limited IMEM requests, in-order response queue to decode.
// Optional FETCH_BYPASS_EN: a response arriving at an empty queue reaches decode the same cycle.
module fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          CLK,
    input  logic          RST,
    fetch_queue_if.master bus
);
    localparam int unsigned   PW  = $clog2(DEPTH);
    localparam logic [31:0]   NOP = 32'h0000_0013;
    localparam logic [PW+1:0] CAP = (PW+2)'(DEPTH);

    logic [31:0]   pc;
    logic [31:0]   q_instr [DEPTH];
    logic [31:0]   q_pc    [DEPTH];
    logic [31:0]   f_pc    [DEPTH];
    logic [PW-1:0] q_rd, q_wr, f_rd, f_wr;
    logic [PW:0]   q_count, outstanding, drop;
    logic [PW:0]   outstanding_next, drop_next;
    logic [PW+1:0] credit_used;
    logic          q_empty, req_fire, resp_ok, resp_keep, q_push, q_pop, bypass_take;

    // Queued plus in-flight never exceeds DEPTH, so a response always has a free slot.
    assign q_empty            = (q_count == '0);
    assign credit_used        = {1'b0, q_count} + {1'b0, outstanding};
    assign bus.IMEM_Req_Valid = !RST && (credit_used < CAP);
    assign bus.IMEM_Addr      = pc;
    assign req_fire           = bus.IMEM_Req_Valid && bus.IMEM_Req_Ready;
    assign resp_ok            = bus.IMEM_Resp_Valid && (outstanding != '0);
    assign resp_keep          = resp_ok && (drop == '0);
    assign q_pop              = !q_empty && !bus.Stall_D && !bus.Flush;
    assign q_push             = resp_keep && !bypass_take && !bus.Flush;

`ifdef FETCH_BYPASS_EN
    logic bypass_hit;
    assign bypass_hit  = resp_keep && q_empty;
    assign bypass_take = bypass_hit && !bus.Stall_D && !bus.Flush;
    assign bus.Valid_D = !q_empty || bypass_hit;
    assign bus.Instr_D = !q_empty ? q_instr[q_rd] : (bypass_hit ? bus.IMEM_Resp_Data : NOP);
    assign bus.PC_D    = !q_empty ? q_pc[q_rd]    : (bypass_hit ? f_pc[f_rd] : 32'h0);
`else
    assign bypass_take = 1'b0;
    assign bus.Valid_D = !q_empty;
    assign bus.Instr_D = q_empty ? NOP   : q_instr[q_rd];
    assign bus.PC_D    = q_empty ? 32'h0 : q_pc[q_rd];
`endif

    // After a redirect every request still in flight is stale, so the drop count
    // becomes the outstanding count left after this cycle's request and response.
    always_comb begin
        outstanding_next = outstanding + {{PW{1'b0}}, req_fire} - {{PW{1'b0}}, resp_ok};
        drop_next        = drop;
        if (bus.Flush)
            drop_next = outstanding_next;
        else if (resp_ok && (drop != '0))
            drop_next = drop - 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            pc          <= RESET_PC;
            q_rd        <= '0;
            q_wr        <= '0;
            q_count     <= '0;
            f_rd        <= '0;
            f_wr        <= '0;
            outstanding <= '0;
            drop        <= '0;
        end else begin
            outstanding <= outstanding_next;
            drop        <= drop_next;
            if (req_fire) f_wr <= f_wr + 1'b1;
            if (resp_ok)  f_rd <= f_rd + 1'b1;
            if (bus.Flush) begin
                pc      <= bus.Redirect_PC & 32'hFFFF_FFFC;
                q_rd    <= '0;
                q_wr    <= '0;
                q_count <= '0;
            end else begin
                if (req_fire) pc   <= pc + 32'd4;
                if (q_push)   q_wr <= q_wr + 1'b1;
                if (q_pop)    q_rd <= q_rd + 1'b1;
                q_count <= q_count + {{PW{1'b0}}, q_push} - {{PW{1'b0}}, q_pop};
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (req_fire)
            f_pc[f_wr] <= pc;
        if (q_push) begin
            q_instr[q_wr] <= bus.IMEM_Resp_Data;
            q_pc[q_wr]    <= f_pc[f_rd];
        end
    end

    assert property (@(posedge CLK) disable iff (RST) !(bus.IMEM_Resp_Valid && (outstanding == '0)));
endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: in-order memory model with adjustable latency,
// directed PC streams pushed as expectations, monitor compares every accepted decode slot.
module tb_fetch_queue;
    localparam int DEPTH = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef FETCH_BYPASS_EN
    localparam int RESP_TO_VALID = 0;
`else
    localparam int RESP_TO_VALID = 1;
`endif

    typedef struct { logic [31:0] addr; int due; } mem_req_t;
    typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    fetch_queue_if bus();

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    int          checks = 0;
    int          errors = 0;
    int          cycle = 0;
    int          lat = 1;
    int          hs_count = 0;
    int          resp_count = 0;
    int          scen_hs = 0;
    int          consumed = 0;
    int          max_inflight = 0;
    int          watch_resp_cycle = 0;
    int          accept_cycle [64];
    logic [31:0] watch_addr = 32'h0;
    mem_req_t    mem_q [$];
    exp_t        sb [$];

    always @(posedge CLK) cycle = cycle + 1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {8'hC3, a[25:2]};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic ready, input logic stall, input logic flush, input logic [31:0] redirect);
        @(negedge CLK);
        bus.IMEM_Req_Ready = ready;
        bus.Stall_D        = stall;
        bus.Flush          = flush;
        bus.Redirect_PC    = redirect;
    endtask

    task automatic loadExpected(input logic [31:0] base, input int n);
        logic [31:0] a;
        for (int i = 0; i < n; i++) begin
            a = base + 32'(4 * i);
            sb.push_back('{pc: a, instr: mem_word(a)});
        end
    endtask

    task automatic waitConsumed(input int target, input int budget, input string name);
        int n = 0;
        while (consumed < target && n < budget) begin
            @(posedge CLK);
            n++;
        end
        checks++;
        if (consumed < target) begin
            errors++;
            $display("[TB] FAIL %s: consumed %0d, expected at least %0d", name, consumed, target);
        end
    endtask

    // Flush cycle plus the cycle after it; old expectations are replaced by the new stream.
    task automatic flushTo(input logic [31:0] target, input logic ready_during,
                           input logic check_busy, input int exp_mem_out);
        logic [31:0] aligned;
        aligned = target & 32'hFFFF_FFFC;
        applyStimulus(ready_during, 1'b0, 1'b1, target);
        sb.delete();
        consumed     = 0;
        scen_hs      = 0;
        max_inflight = 0;
        watch_addr   = aligned;
        loadExpected(aligned, 64);
        #4;
        if (check_busy) begin
            checkOutput("flush_with_resp", 32'(bus.IMEM_Resp_Valid), 32'd1);
            checkOutput("flush_with_req", 32'(bus.IMEM_Req_Valid && bus.IMEM_Req_Ready), 32'd1);
        end
        if (exp_mem_out >= 0)
            checkOutput("flush_outstanding", 32'(hs_count - resp_count), 32'(exp_mem_out));
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        #4;
        checkOutput("flush_valid_clear", 32'(bus.Valid_D), 32'd0);
        checkOutput("redirect_addr", bus.IMEM_Addr, aligned);
    endtask

    initial begin
        mem_req_t r;
        bus.IMEM_Resp_Valid = 1'b0;
        bus.IMEM_Resp_Data  = 32'h0;
        forever begin
            @(negedge CLK);
            bus.IMEM_Resp_Valid = 1'b0;
            bus.IMEM_Resp_Data  = 32'h0;
            if (RST) begin
                mem_q.delete();
            end else if (mem_q.size() > 0 && mem_q[0].due <= cycle) begin
                r = mem_q.pop_front();
                bus.IMEM_Resp_Valid = 1'b1;
                bus.IMEM_Resp_Data  = mem_word(r.addr);
                resp_count++;
                if (r.addr == watch_addr) watch_resp_cycle = cycle;
            end
            #2;
            if (!RST && bus.IMEM_Req_Valid && bus.IMEM_Req_Ready) begin
                mem_q.push_back('{addr: bus.IMEM_Addr, due: cycle + lat});
                hs_count++;
                if (!bus.Flush) scen_hs++;
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            #3;
            if (!RST && bus.Valid_D && !bus.Stall_D && !bus.Flush) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL decode_stream: got pc=%h instr=%h, expected nothing", bus.PC_D, bus.Instr_D);
                end else begin
                    e = sb.pop_front();
                    if (bus.PC_D !== e.pc || bus.Instr_D !== e.instr) begin
                        errors++;
                        $display("[TB] FAIL decode_stream: got pc=%h instr=%h, expected pc=%h instr=%h",
                                 bus.PC_D, bus.Instr_D, e.pc, e.instr);
                    end
                end
                if (consumed < 64) accept_cycle[consumed] = cycle;
                consumed++;
            end
            if (!RST && !bus.Flush && (scen_hs - consumed) > max_inflight)
                max_inflight = scen_hs - consumed;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.IMEM_Req_Ready = 1'b1;
        bus.Stall_D        = 1'b0;
        bus.Flush          = 1'b0;
        bus.Redirect_PC    = 32'h0;
        watch_addr         = RESET_PC;
        loadExpected(RESET_PC, 64);
        $display("[TB] reset and straight-line stream");
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        #4;
        checkOutput("reset_req_valid", 32'(bus.IMEM_Req_Valid), 32'd0);
        checkOutput("reset_addr", bus.IMEM_Addr, RESET_PC);
        checkOutput("reset_valid_d", 32'(bus.Valid_D), 32'd0);
        checkOutput("reset_instr_d", bus.Instr_D, 32'h0000_0013);
        checkOutput("reset_pc_d", bus.PC_D, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        RST = 1'b0;
        #4;
        checkOutput("first_req_valid", 32'(bus.IMEM_Req_Valid), 32'd1);
        checkOutput("first_req_addr", bus.IMEM_Addr, RESET_PC);
        waitConsumed(14, 60, "stream_drain");
        checkOutput("stream_throughput", 32'(accept_cycle[12] - accept_cycle[4]), 32'd8);
        checkOutput("empty_resp_latency", 32'(accept_cycle[0] - watch_resp_cycle), 32'(RESP_TO_VALID));

        $display("[TB] decode stall and memory back-pressure");
        flushTo(32'h0000_1000, 1'b1, 1'b0, -1);
        waitConsumed(3, 30, "pre_stall");
        repeat (5) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        #4;
        checkOutput("stall_req_valid_low", 32'(bus.IMEM_Req_Valid), 32'd0);
        checkOutput("stall_credit_full", 32'(scen_hs - consumed), 32'(DEPTH));
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        waitConsumed(20, 60, "post_stall");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
            #4;
            checkOutput("ready_low_addr_hold", bus.IMEM_Addr, 32'h0000_1000 + 32'(4 * scen_hs));
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        waitConsumed(28, 60, "post_ready_low");
        checkOutput("credit_bound", 32'(max_inflight <= DEPTH), 32'd1);

        $display("[TB] redirect with three requests in flight");
        repeat (8) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        lat = 8;
        repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        lat = 1;
        flushTo(32'h0000_0102, 1'b0, 1'b0, 3);
        waitConsumed(6, 80, "redirect_stream");
        checkOutput("redirect_first_latency", 32'(accept_cycle[0] - watch_resp_cycle), 32'(RESP_TO_VALID));

        $display("[TB] redirect colliding with response and request, PC wrap");
        lat = 2;
        waitConsumed(14, 80, "latency2_stream");
        flushTo(32'hFFFF_FFFA, 1'b1, 1'b1, -1);
        waitConsumed(8, 80, "wrap_stream");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
